posit_addsub_sched: RTL and testbench

Scheduler that shares one posit add/sub datapath between `N_REQ` requesters. Each requester presents two 8-bit posit operands and an add/sub select over a valid/ready handshake. The block picks one request round-robin and holds its operands stable on the datapath inputs for `DP_LATENCY` cycles, then captures the result. It returns the result to the issuing requester through a per-requester valid/ready response. It sits between the ALU front-end ports and the single posit add/sub instance.

---
 rtl/posit_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/posit_addsub_sched.sv | 118 +++++++++++
 tb/tb_posit_addsub_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
`timescale 1ns/1ps
// Shared types for the posit add/sub scheduler: operand width, operand type and FSM states.
package posit_pkg;
  localparam int POSIT_W = 8;

  typedef logic [POSIT_W-1:0] posit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } sched_state_e;
endpackage

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
// Combinational round-robin arbiter: grants the first set request at or after ptr,
// wrapping past N-1 with an explicit compare so non-power-of-two N works.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    // Walk from the farthest offset down so the nearest valid requester wins last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[IW'(j)]) begin
        gnt          = '0;
        gnt[IW'(j)]  = 1'b1;
        idx          = IW'(j);
      end
    end
  end
endmodule

// File: rtl/posit_addsub_sched.sv
`timescale 1ns/1ps
// Shares one external posit add/sub datapath between N_REQ requesters: round-robin accept,
// hold operands for DP_LATENCY cycles, capture the result, return it to the issuer.
module posit_addsub_sched
  import posit_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DP_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [POSIT_W*N_REQ-1:0]   req_posit1,
  input  logic [POSIT_W*N_REQ-1:0]   req_posit2,
  input  logic [N_REQ-1:0]           req_add_sub,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [POSIT_W-1:0]         rsp_result,
  output logic [POSIT_W-1:0]         dp_posit1,
  output logic [POSIT_W-1:0]         dp_posit2,
  output logic                       dp_add_sub,
  input  logic [POSIT_W-1:0]         dp_result,
  output logic                       busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DP_LATENCY - 1);
  localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);

  sched_state_e     state_reg;
  logic [IW-1:0]    ptr_reg;
  logic [IW-1:0]    id_reg;
  logic [CW-1:0]    cnt_reg;
  posit_t           res_reg;
  posit_t           dp_posit1_reg;
  posit_t           dp_posit2_reg;
  logic             dp_add_sub_reg;
  logic [N_REQ-1:0] rsp_valid_reg;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  logic             accept;
  posit_t           op1_arr [N_REQ];
  posit_t           op2_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op1_arr[gi] = req_posit1[gi*POSIT_W +: POSIT_W];
      assign op2_arr[gi] = req_posit2[gi*POSIT_W +: POSIT_W];
    end
  endgenerate

  rr_arbiter #(
    .N (N_REQ),
    .IW(IW)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr_reg),
    .gnt(gnt),
    .idx(gnt_idx)
  );

  // rst_n gates the grant so req_ready is low throughout reset, not just after it.
  assign req_ready  = (state_reg == IDLE && rst_n) ? gnt : '0;
  assign accept     = (state_reg == IDLE) && (|gnt);
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = res_reg;
  assign dp_posit1  = dp_posit1_reg;
  assign dp_posit2  = dp_posit2_reg;
  assign dp_add_sub = dp_add_sub_reg;
  assign busy       = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      id_reg         <= '0;
      cnt_reg        <= '0;
      res_reg        <= '0;
      dp_posit1_reg  <= '0;
      dp_posit2_reg  <= '0;
      dp_add_sub_reg <= 1'b0;
      rsp_valid_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            dp_posit1_reg  <= op1_arr[gnt_idx];
            dp_posit2_reg  <= op2_arr[gnt_idx];
            dp_add_sub_reg <= req_add_sub[gnt_idx];
            id_reg         <= gnt_idx;
            cnt_reg        <= LAST_CNT;
            state_reg      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            res_reg       <= dp_result;
            rsp_valid_reg <= N_REQ'(1) << id_reg;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[id_reg]) begin
            rsp_valid_reg <= '0;
            ptr_reg       <= (id_reg == LAST_ID) ? '0 : id_reg + 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_posit_addsub_sched.sv
`timescale 1ns/1ps
// Bench for posit_addsub_sched (N_REQ=3, DP_LATENCY=3): directed vectors, expected responses
// queued at issue and checked by a negedge monitor; datapath model corrupts off-sample cycles.
module tb_posit_addsub_sched;
  localparam int N   = 3;
  localparam int LAT = 3;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [8*N-1:0]   req_posit1;
  logic [8*N-1:0]   req_posit2;
  logic [N-1:0]     req_add_sub;
  logic [N-1:0]     rsp_valid;
  logic [N-1:0]     rsp_ready;
  logic [7:0]       rsp_result;
  logic [7:0]       dp_posit1;
  logic [7:0]       dp_posit2;
  logic             dp_add_sub;
  logic [7:0]       dp_result;
  logic             busy;

  posit_addsub_sched #(
    .N_REQ     (N),
    .DP_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_posit1 (req_posit1),
    .req_posit2 (req_posit2),
    .req_add_sub(req_add_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .dp_posit1  (dp_posit1),
    .dp_posit2  (dp_posit2),
    .dp_add_sub (dp_add_sub),
    .dp_result  (dp_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int         id;
    logic [7:0] res;
  } exp_t;
  exp_t sb[$];

  int acc_cnt [N];
  logic [N-1:0] acc_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Datapath model: correct only in the cycle the scheduler should sample it.
  int dp_age = 100;
  logic [7:0] dp_good;
  assign dp_good   = dp_add_sub ? (dp_posit1 - dp_posit2) : (dp_posit1 + dp_posit2);
  assign dp_result = (dp_age == LAT - 1) ? dp_good : (dp_good ^ 8'hA5);

  always @(posedge clk) begin
    if (|(req_valid & req_ready)) dp_age <= 0;
    else if (dp_age < 100) dp_age <= dp_age + 1;
  end

  // Requester behaviour: drop valid once accepted, count accepts per index.
  initial for (int i = 0; i < N; i++) acc_cnt[i] = 0;
  always @(posedge clk) begin
    acc_now = req_valid & req_ready;
    for (int i = 0; i < N; i++) if (acc_now[i]) acc_cnt[i]++;
    #1 req_valid = req_valid & ~acc_now;
  end

  // Monitor: compare every completed response handshake against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rsp_valid != '0) chk("rsp_onehot", $onehot(rsp_valid), 1);
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_rsp: got id=%0d result=%02h, required no response", i, rsp_result);
          end else begin
            e = sb.pop_front();
            $display("rsp  id=%0d result=%02h (expected id=%0d result=%02h)", i, rsp_result, e.id, e.res);
            chk("rsp_id", i, e.id);
            chk("rsp_result", rsp_result, e.res);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b, input logic op);
    req_posit1[idx*8 +: 8] = a;
    req_posit2[idx*8 +: 8] = b;
    req_add_sub[idx]       = op;
    req_valid[idx]         = 1'b1;
  endtask

  task automatic push(input int idx, input logic [7:0] res);
    exp_t e;
    e.id  = idx;
    e.res = res;
    sb.push_back(e);
    $display("issue id=%0d a=%02h b=%02h op=%0d expect=%02h", idx,
             req_posit1[idx*8 +: 8], req_posit2[idx*8 +: 8], req_add_sub[idx], res);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || req_valid != '0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_done", n < 100, 1);
  endtask

  task automatic wait_accept(input int idx);
    int start;
    int n;
    start = acc_cnt[idx];
    n = 0;
    while (acc_cnt[idx] == start && n < 100) begin
      tick();
      n++;
    end
    chk($sformatf("accept_%0d", idx), n < 100, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n       = 1'b0;
    req_valid   = '1;
    rsp_ready   = '0;
    req_posit1  = '0;
    req_posit2  = '0;
    req_add_sub = '0;

    // Reset state, with requests pending.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_dp", {dp_posit1, dp_posit2, dp_add_sub}, 0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // Simultaneous requests, round-robin order, third round back to req0.
    rsp_ready = '1;
    set_req(0, 8'h10, 8'h04, 1'b1);
    set_req(1, 8'h30, 8'h01, 1'b0);
    push(0, 8'h0C);
    push(1, 8'h31);
    #1 chk("rr_first_grant", req_ready, 3'b001);
    drain();
    set_req(0, 8'h05, 8'h03, 1'b0);
    set_req(1, 8'h7F, 8'h01, 1'b1);
    push(0, 8'h08);
    push(1, 8'h7E);
    #1 chk("rr_third_grant", req_ready, 3'b001);
    drain();

    // Single add: operand hold and response latency.
    set_req(0, 8'h40, 8'h20, 1'b0);
    push(0, 8'h60);
    #1 chk("single_grant", req_ready, 3'b001);
    tick();
    chk("busy_after_accept", busy, 1);
    chk("ready_in_wait", req_ready, 0);
    k = 0;
    while (!rsp_valid[0] && k < 20) begin
      chk("dp_hold", {dp_posit1, dp_posit2, dp_add_sub}, {8'h40, 8'h20, 1'b0});
      tick();
      k++;
    end
    chk("rsp_latency", k, LAT);
    chk("busy_in_resp", busy, 1);
    tick();
    chk("busy_after_rsp", busy, 0);
    chk("rsp_valid_cleared", rsp_valid, 0);

    // Response backpressure; a request raised during WAIT must wait.
    rsp_ready = '0;
    set_req(0, 8'h22, 8'h11, 1'b0);
    push(0, 8'h33);
    tick();
    set_req(1, 8'h50, 8'h10, 1'b1);
    push(1, 8'h40);
    #1 chk("ready_blocked_wait", req_ready, 0);
    k = 0;
    while (!rsp_valid[0] && k < 20) begin
      tick();
      k++;
    end
    chk("bp_rsp_seen", rsp_valid, 3'b001);
    rsp_ready = 3'b110;
    repeat (5) begin
      tick();
      chk("bp_valid", rsp_valid, 3'b001);
      chk("bp_result", rsp_result, 8'h33);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = '1;
    tick();
    chk("req1_ready_after_rsp", req_ready, 3'b010);
    drain();

    // Reset in WAIT drops the operation and clears the pointer.
    set_req(2, 8'h01, 8'h01, 1'b1);
    tick();
    chk("busy_before_reset", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_dp", {dp_posit1, dp_posit2, dp_add_sub}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    set_req(0, 8'h0F, 8'h01, 1'b0);
    set_req(2, 8'h00, 8'h01, 1'b1);
    push(0, 8'h10);
    push(2, 8'hFF);
    #1 chk("grant_after_reset", req_ready, 3'b001);
    drain();

    // Three-way wrap: req2 served while all are valid, then back to req0.
    set_req(0, 8'h01, 8'h02, 1'b0);
    set_req(1, 8'h0A, 8'h05, 1'b1);
    set_req(2, 8'h80, 8'h80, 1'b0);
    push(0, 8'h03);
    push(1, 8'h05);
    push(2, 8'h00);
    wait_accept(0);
    set_req(0, 8'h11, 8'h11, 1'b0);
    push(0, 8'h22);
    wait_accept(1);
    set_req(1, 8'h20, 8'h30, 1'b1);
    push(1, 8'hF0);
    wait_accept(2);
    k = 0;
    while (busy && k < 20) begin
      tick();
      k++;
    end
    chk("wrap_grant", req_ready, 3'b001);
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
